// File: rtl/sw_pkg.sv
// Shared definitions for the switch bit-serial link (producer and collector).
package sw_pkg;

    localparam int SW_MAX_BITS = 8;
    localparam int SW_LEN_W    = 3;
    localparam int SW_WORD_W   = SW_LEN_W + SW_MAX_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2,
        DROP    = 2'd3
    } sw_state_t;

endpackage

// File: rtl/sw_encode_if.sv
// Bit-serial link plus assembled-word outputs of the switch collector.
interface sw_encode_if
    import sw_pkg::*;
#(
    parameter int MAX_BITS = SW_MAX_BITS,
    parameter int LEN_W    = SW_LEN_W
);

    logic                      bit_valid;
    logic                      bit_value;
    logic                      bits_done;
    logic                      next_bit;
    logic [LEN_W+MAX_BITS-1:0] sw;
    logic                      word_valid;
    logic                      overflow;

    // Bit source side: drives the serial stream, observes ready and results.
    modport master (
        output bit_valid,
        output bit_value,
        output bits_done,
        input  next_bit,
        input  sw,
        input  word_valid,
        input  overflow
    );

    // Collector side.
    modport slave (
        input  bit_valid,
        input  bit_value,
        input  bits_done,
        output next_bit,
        output sw,
        output word_valid,
        output overflow
    );

endinterface

// File: rtl/sw_encode_bit_pack_reg.sv
// Pattern shift-in register and bit counter for one frame. Bits are placed
// MSB first; the look-ahead outputs let the caller close a frame in the same
// cycle its last bit arrives.
module bit_pack_reg
    import sw_pkg::*;
#(
    parameter int MAX_BITS = SW_MAX_BITS,
    parameter int LEN_W    = SW_LEN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load_bit,
    input  logic                bit_value,
    output logic [MAX_BITS-1:0] pattern_nxt,
    output logic [LEN_W:0]      count_nxt,
    output logic [LEN_W:0]      count,
    output logic                full
);

    logic [MAX_BITS-1:0] pattern_r;
    logic [LEN_W:0]      count_r;
    logic [MAX_BITS-1:0] pattern_nxt_s;
    logic [LEN_W:0]      count_nxt_s;
    logic [LEN_W-1:0]    idx_s;
    logic                full_s;

    // Next pattern/count: clear wins over load; loads are refused once full.
    always_comb begin
        pattern_nxt_s = pattern_r;
        count_nxt_s   = count_r;
        full_s        = (count_r == (LEN_W+1)'(MAX_BITS));
        idx_s         = LEN_W'(MAX_BITS - 1) - count_r[LEN_W-1:0];
        if (clear) begin
            pattern_nxt_s = {MAX_BITS{1'b0}};
            count_nxt_s   = {(LEN_W+1){1'b0}};
        end else if (load_bit && !full_s) begin
            pattern_nxt_s[idx_s] = bit_value;
            count_nxt_s          = count_r + (LEN_W+1)'(1);
        end else begin
            pattern_nxt_s = pattern_r;
            count_nxt_s   = count_r;
        end
    end

    // Pattern and count state, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_r <= {MAX_BITS{1'b0}};
            count_r   <= {(LEN_W+1){1'b0}};
        end else begin
            pattern_r <= pattern_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    assign pattern_nxt = pattern_nxt_s;
    assign count_nxt   = count_nxt_s;
    assign count       = count_r;
    assign full        = full_s;

endmodule

// File: rtl/sw_encode.sv
// Serial-to-parallel collector: packs up to MAX_BITS serial bits into the
// {len, pattern} switch word and emits it on the frame-end strobe.
module sw_encode
    import sw_pkg::*;
#(
    parameter int MAX_BITS = SW_MAX_BITS,
    parameter int LEN_W    = SW_LEN_W
) (
    input  logic            clk,
    input  logic            rst,
    sw_encode_if.slave      bus
);

    sw_state_t                 state_r;
    logic [LEN_W+MAX_BITS-1:0] sw_r;
    logic                      word_valid_r;
    logic                      overflow_r;
    logic                      drop_done_r;

    logic                      next_bit_s;
    logic                      accept_s;
    logic                      frame_open_s;
    logic                      load_s;
    logic                      clear_s;
    logic [MAX_BITS-1:0]       pattern_nxt_s;
    logic [LEN_W:0]            count_nxt_s;
    logic [LEN_W:0]            count_s;
    logic                      full_s;
    logic [LEN_W-1:0]          len_s;

    bit_pack_reg #(
        .MAX_BITS (MAX_BITS),
        .LEN_W    (LEN_W)
    ) u_pack (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_s),
        .load_bit    (load_s),
        .bit_value   (bus.bit_value),
        .pattern_nxt (pattern_nxt_s),
        .count_nxt   (count_nxt_s),
        .count       (count_s),
        .full        (full_s)
    );

    // Ready decode: only the single EMIT cycle refuses input.
    always_comb begin
        case (state_r)
            EMIT:    next_bit_s = 1'b0;
            default: next_bit_s = 1'b1;
        endcase
    end

    // Pack-register control: a 9th accepted bit clears, EMIT clears for the next frame.
    always_comb begin
        accept_s     = bus.bit_valid && next_bit_s;
        frame_open_s = (state_r == IDLE) || (state_r == COLLECT);
        load_s       = 1'b0;
        clear_s      = 1'b0;
        if (state_r == EMIT) begin
            clear_s = 1'b1;
        end else if (frame_open_s && accept_s) begin
            if (full_s) begin
                clear_s = 1'b1;
            end else begin
                load_s = 1'b1;
            end
        end else begin
            clear_s = 1'b0;
        end
    end

    // Length field is count-1; the 3-bit wrap maps a count of 8 to 7.
    assign len_s = count_nxt_s[LEN_W-1:0] - LEN_W'(1);

    // Frame FSM with registered word/valid/overflow outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            sw_r         <= {(LEN_W+MAX_BITS){1'b0}};
            word_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            drop_done_r  <= 1'b0;
        end else begin
            word_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            case (state_r)
                IDLE, COLLECT: begin
                    if (accept_s && full_s) begin
                        overflow_r  <= 1'b1;
                        drop_done_r <= bus.bits_done;
                        state_r     <= DROP;
                    end else if (bus.bits_done && (accept_s || (state_r == COLLECT))) begin
                        sw_r         <= {len_s, pattern_nxt_s};
                        word_valid_r <= 1'b1;
                        state_r      <= EMIT;
                    end else if (accept_s) begin
                        state_r <= COLLECT;
                    end else begin
                        state_r <= state_r;
                    end
                end
                EMIT: begin
                    state_r <= IDLE;
                end
                DROP: begin
                    if (drop_done_r || bus.bits_done) begin
                        drop_done_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.next_bit   = next_bit_s;
    assign bus.sw         = sw_r;
    assign bus.word_valid = word_valid_r;
    assign bus.overflow   = overflow_r;

endmodule

// File: tb/tb_sw_encode.sv
// Directed self-checking bench for the switch-word collector.
module tb_sw_encode;
    import sw_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sw_encode_if bus ();

    sw_encode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of link inputs; outputs are observed 1 time unit after the edge.
    task automatic drive(input logic v, input logic b, input logic d);
        bus.bit_valid = v;
        bus.bit_value = b;
        bus.bits_done = d;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.bit_value = 1'b0;
        bus.bits_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.sw !== 11'd0) begin errors++; $display("FAIL reset_sw got %b want %b", bus.sw, 11'd0); end
        checks++;
        if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL reset_wv got %b want 0", bus.word_valid); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
        checks++;
        if (bus.next_bit !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.next_bit); end
        rst = 1'b1;
    endtask

    task automatic test_three_bits();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL three_early_wv got %b want 0", bus.word_valid); end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1) begin errors++; $display("FAIL three_wv got %b want 1", bus.word_valid); end
        checks++;
        if (bus.sw !== 11'b010_10100000) begin errors++; $display("FAIL three_sw got %b want %b", bus.sw, 11'b010_10100000); end
        checks++;
        if (bus.next_bit !== 1'b0) begin errors++; $display("FAIL emit_ready got %b want 0", bus.next_bit); end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL three_wv_drop got %b want 0", bus.word_valid); end
        checks++;
        if (bus.sw !== 11'b010_10100000) begin errors++; $display("FAIL three_sw_hold got %b want %b", bus.sw, 11'b010_10100000); end
        checks++;
        if (bus.next_bit !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", bus.next_bit); end
    endtask

    task automatic test_eight_ones();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL eight_ovf got %b want 0", bus.overflow); end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.sw !== 11'b111_11111111) begin
            errors++; $display("FAIL eight_sw got wv=%b sw=%b want wv=1 sw=%b", bus.word_valid, bus.sw, 11'b111_11111111);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_cycle();
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.sw !== 11'b000_10000000) begin
            errors++; $display("FAIL single_sw got wv=%b sw=%b want wv=1 sw=%b", bus.word_valid, bus.sw, 11'b000_10000000);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", bus.overflow); end
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", bus.overflow); end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_once got %b want 0", bus.overflow); end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b0 || bus.sw !== 11'b000_10000000) begin
            errors++; $display("FAIL drop_done got wv=%b sw=%b want wv=0 sw=%b", bus.word_valid, bus.sw, 11'b000_10000000);
        end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.sw !== 11'b000_10000000) begin
            errors++; $display("FAIL after_drop got wv=%b sw=%b want wv=1 sw=%b", bus.word_valid, bus.sw, 11'b000_10000000);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow_with_done();
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.overflow !== 1'b1 || bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_done got ovf=%b wv=%b want ovf=1 wv=0", bus.overflow, bus.word_valid);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.sw !== 11'b000_00000000) begin
            errors++; $display("FAIL ovf_done_idle got wv=%b sw=%b want wv=1 sw=%b", bus.word_valid, bus.sw, 11'b000_00000000);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_empty_and_emit();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b0 || bus.sw !== 11'b000_10000000) begin
            errors++; $display("FAIL empty_frame got wv=%b sw=%b want wv=0 sw=%b", bus.word_valid, bus.sw, 11'b000_10000000);
        end
        drive(1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.sw !== 11'b000_00000000) begin
            errors++; $display("FAIL zero_bit got wv=%b sw=%b want wv=1 sw=%b", bus.word_valid, bus.sw, 11'b000_00000000);
        end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b0) begin errors++; $display("FAIL emit_ignore got %b want 0", bus.word_valid); end
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.sw !== 11'b000_10000000) begin
            errors++; $display("FAIL emit_not_counted got wv=%b sw=%b want wv=1 sw=%b", bus.word_valid, bus.sw, 11'b000_10000000);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        checks++;
        if (bus.word_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.sw !== 11'd0) begin
            errors++; $display("FAIL mid_reset got wv=%b ovf=%b sw=%b want 0 0 0", bus.word_valid, bus.overflow, bus.sw);
        end
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.sw !== 11'b001_01000000) begin
            errors++; $display("FAIL post_reset got wv=%b sw=%b want wv=1 sw=%b", bus.word_valid, bus.sw, 11'b001_01000000);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_value = 1'b0;
        bus.bits_done = 1'b0;
        #2;
        test_reset();
        test_three_bits();
        test_eight_ones();
        test_single_cycle();
        test_overflow();
        test_overflow_with_done();
        test_empty_and_emit();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_encode.md
# sw_encode

Serial-to-parallel collector: the receive end of the switch bit-serial link. Accepts bits one at a time with a valid strobe, packs up to 8 of them plus a length field into the 11-bit switch-word format, and emits the word when the frame-end strobe arrives. It sits downstream of any bit source that speaks the `next_bit` / `bit_value` / `bits_done` protocol and rebuilds the original `sw[10:0]` word.

## Interface
Parameters:
- `MAX_BITS`, 8: maximum bits per frame (pattern field width).
- `LEN_W`, 3: length field width; `$clog2(MAX_BITS)`.
- Word width is derived: `LEN_W + MAX_BITS` = 11.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous reset, active-low. One clock; reset is synchronous and active-low.
- `bit_valid`, in, 1: `bit_value` is valid this cycle.
- `bit_value`, in, 1: serial data bit.
- `bits_done`, in, 1: frame-end strobe.
- `next_bit`, out, 1: ready; a bit is accepted only when `bit_valid && next_bit`.
- `sw`, out, 11: assembled word `{len[2:0], pattern[7:0]}`. Held until the next emit.
- `word_valid`, out, 1: one-cycle pulse when `sw` updates.
- `overflow`, out, 1: one-cycle pulse on the 9th bit of a frame.

## Operation
- States:
  - IDLE: waiting for the first bit; `next_bit`=1.
  - COLLECT: accumulating bits; `next_bit`=1.
  - EMIT: `word_valid`=1, `next_bit`=0, lasts 1 cycle.
  - DROP: overflowed frame; `next_bit`=1, bits are discarded.
- IDLE:
  - Accepted bit: store it, count=1, go to COLLECT.
  - `bits_done` with no accepted bit: empty frame; ignored, stay in IDLE, no output.
- COLLECT:
  - Each accepted bit is written to `pattern[MAX_BITS-count]`, so the first bit lands in `pattern[7]`. The word is left-aligned and unused low bits read 0. Then count++.
  - `bits_done`: latch `sw = {count-1, pattern}` and go to EMIT. The len field is the bit count minus 1 (1..8 maps to 0..7).
  - Accepted bit when count==MAX_BITS: pulse `overflow`, clear count and pattern, go to DROP.
- DROP: ignore bits. `bits_done` returns to IDLE with no `word_valid` and `sw` unchanged.
- EMIT: returns to IDLE unconditionally. Input on the EMIT cycle is not accepted (`next_bit`=0). `bits_done` on that cycle is ignored.
- Same cycle `bit_valid && bits_done` in IDLE/COLLECT: accept the bit first, then close the frame with the updated count. A 1-bit frame is therefore legal in a single cycle.
  - If that bit is the 9th, overflow wins: go to DROP, then `bits_done` is already consumed, so return to IDLE next cycle.
- `bit_value` is ignored when `bit_valid`=0.

## Timing
- Reset values: state=IDLE, count=0, pattern=0, `sw`=0, `word_valid`=0, `overflow`=0, `next_bit`=1 (combinational from state). Reset mid-frame discards the partial frame with no pulse.
- `word_valid` is asserted the cycle after `bits_done` is sampled. `sw` is valid in the same cycle and stays stable after.
- `overflow` is asserted the cycle after the 9th bit is sampled.
- Throughput: one bit per cycle; frame gap ≥1 cycle (EMIT).
- All outputs are registered except `next_bit`, which is decoded from state.

## Structure
- Package `sw_pkg`:
  - `typedef enum logic [1:0] {IDLE, COLLECT, EMIT, DROP} sw_state_t`
  - Constants `SW_MAX_BITS=8`, `SW_LEN_W=3`, `SW_WORD_W=11`.
  - The producer-side block shares these.
- One sub-module, `bit_pack_reg`: the pattern register plus count, with `clear`, `load_bit`, `count`, and `full` signals. Top level holds the FSM and output registers.

## Test plan
- Reset, then bits 1,0,1 on consecutive cycles, then `bits_done` -> next cycle `word_valid`=1 and `sw`=11'b010_10100000. `word_valid` drops after 1 cycle.
- Eight 1s then `bits_done` -> `sw`=11'b111_11111111.
- Single cycle with `bit_valid`=1, `bit_value`=1, `bits_done`=1 from IDLE -> `sw`=11'b000_10000000.
- Nine bits -> `overflow` pulses once after the 9th bit. Further bits are ignored, `bits_done` gives no `word_valid`, and `sw` keeps its previous value.
- `bits_done` alone in IDLE -> no `word_valid`, `sw` unchanged. Also, `bit_valid` during EMIT is not accepted: `next_bit`=0, and the bit is not counted in the next frame.
- Assert `rst`=0 after 3 bits, release, then send 0,1 + `bits_done` -> `sw`=11'b001_01000000, with no output from the aborted frame.
